// File: rtl/pc_seq_pkg.sv
// Shared decode constants for the PC sequencer: opcode, subop codes and
// instruction field positions.
package pc_seq_pkg;

   localparam logic [1:0] OPC_CTRL = 2'd2;

   localparam logic [3:0] SUB_BR   = 4'd0;
   localparam logic [3:0] SUB_JMP  = 4'd1;
   localparam logic [3:0] SUB_CALL = 4'd2;
   localparam logic [3:0] SUB_RET  = 4'd3;

   localparam int OPC_LSB  = 0;
   localparam int COND_LSB = 2;
   localparam int TGT_LSB  = 4;
   localparam int SUB_LSB  = 12;

   function automatic logic is_ctrl(input logic [1:0] opcode);
      return (opcode == OPC_CTRL);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/ALU-side bundle of the PC sequencer; the sequencer takes the slave side.
interface pc_sequencer_if #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 8,
   parameter int DEPTH   = 4
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic               step;
   logic [INSTR_W-1:0] instruction;
   logic [15:0]        alu_flags;
   logic               load_en;
   logic [PC_W-1:0]    load_pc;
   logic [PC_W-1:0]    pc;
   logic               pc_valid;
   logic               taken;
   logic [DW-1:0]      stack_depth;
   logic               overflow;
   logic               underflow;

   modport master (
      output step, instruction, alu_flags, load_en, load_pc,
      input  pc, pc_valid, taken, stack_depth, overflow, underflow
   );

   modport slave (
      input  step, instruction, alu_flags, load_en, load_pc,
      output pc, pc_valid, taken, stack_depth, overflow, underflow
   );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address LIFO. Push on full and pop on empty are ignored;
// the parent never requests both in the same cycle.
module return_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_top,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_count;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;

   assign w_wr_idx  = r_count[AW-1:0];
   assign w_top_idx = r_count[AW-1:0] - AW'(1);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == (AW+1)'(0));
   assign o_count   = r_count;
   assign o_top     = r_mem[w_top_idx];

   // Entry storage; contents are don't-care after reset.
   always_ff @(posedge i_clk) begin
      if (i_push && !o_full && !i_reset) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   // Occupancy counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_push && !o_full) begin
         r_count <= r_count + (AW+1)'(1);
      end else if (i_pop && !o_empty) begin
         r_count <= r_count - (AW+1)'(1);
      end else begin
         r_count <= r_count;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: computes next PC on each step pulse for sequential,
// branch, jump, call and return instructions, with a hardware return stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              INSTR_W  = 16,
   parameter int              PC_W     = 8,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic           i_clk,
   input logic           i_reset,
   pc_sequencer_if.slave bus
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic [INSTR_W-1:0] w_instr;
   logic [1:0]         w_opcode;
   logic [1:0]         w_cond;
   logic [3:0]         w_subop;
   logic [PC_W-1:0]    w_target;
   logic [PC_W-1:0]    w_seq;
   logic [PC_W-1:0]    w_next_pc;
   logic               w_taken;
   logic               w_push;
   logic               w_pop;
   logic               w_set_ovf;
   logic               w_set_unf;
   logic               w_accept;
   logic [PC_W-1:0]    w_top;
   logic               w_full;
   logic               w_empty;
   logic [DW-1:0]      w_count;
   logic               w_unused_flags;

   logic [PC_W-1:0]    r_pc;
   logic               r_pc_valid;
   logic               r_taken;
   logic               r_overflow;
   logic               r_underflow;

   assign w_instr        = bus.instruction;
   assign w_opcode       = w_instr[OPC_LSB +: 2];
   assign w_cond         = w_instr[COND_LSB +: 2];
   assign w_subop        = w_instr[SUB_LSB +: 4];
   assign w_target       = w_instr[TGT_LSB +: PC_W];
   assign w_seq          = r_pc + PC_W'(1);
   assign w_unused_flags = ^bus.alu_flags[15:2];

   // A step only counts when no load is competing for the PC.
   assign w_accept = bus.step & ~bus.load_en;

   // Next-PC decode for the instruction being retired.
   always_comb begin
      w_next_pc = w_seq;
      w_taken   = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (is_ctrl(w_opcode)) begin
         case (w_subop)
            SUB_BR: begin
               if (w_cond == bus.alu_flags[1:0]) begin
                  w_next_pc = w_target;
                  w_taken   = 1'b1;
               end else begin
                  w_next_pc = w_seq;
                  w_taken   = 1'b0;
               end
            end
            SUB_JMP: begin
               w_next_pc = w_target;
               w_taken   = 1'b1;
            end
            SUB_CALL: begin
               w_next_pc = w_target;
               w_taken   = 1'b1;
               if (!w_full) begin
                  w_push = 1'b1;
               end else begin
                  w_set_ovf = 1'b1;
               end
            end
            SUB_RET: begin
               if (!w_empty) begin
                  w_next_pc = w_top;
                  w_taken   = 1'b1;
                  w_pop     = 1'b1;
               end else begin
                  w_next_pc = w_seq;
                  w_set_unf = 1'b1;
               end
            end
            default: begin
               w_next_pc = w_seq;
            end
         endcase
      end else begin
         w_next_pc = w_seq;
      end
   end

   return_stack #(
      .WIDTH (PC_W),
      .DEPTH (DEPTH)
   ) u_stack (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push & w_accept),
      .i_pop   (w_pop & w_accept),
      .i_data  (w_seq),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // PC register, update strobe and sticky stack-error flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc        <= RESET_PC;
         r_pc_valid  <= 1'b0;
         r_taken     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.load_en) begin
         r_pc       <= bus.load_pc;
         r_pc_valid <= 1'b1;
         r_taken    <= 1'b0;
      end else if (bus.step) begin
         r_pc        <= w_next_pc;
         r_pc_valid  <= 1'b1;
         r_taken     <= w_taken;
         r_overflow  <= r_overflow | w_set_ovf;
         r_underflow <= r_underflow | w_set_unf;
      end else begin
         r_pc_valid <= 1'b0;
         r_taken    <= 1'b0;
      end
   end

   assign bus.pc          = r_pc;
   assign bus.pc_valid    = r_pc_valid;
   assign bus.taken       = r_taken;
   assign bus.stack_depth = w_count;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer (PC_W=8, DEPTH=4, RESET_PC=0x10).
module tb_pc_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.INSTR_W(16), .PC_W(8), .DEPTH(4)) bus ();

   pc_sequencer #(
      .INSTR_W  (16),
      .PC_W     (8),
      .DEPTH    (4),
      .RESET_PC (8'h10)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   typedef struct {
      logic        ld;
      logic [7:0]  lpc;
      logic        st;
      logic [15:0] ins;
      logic [15:0] fl;
      logic [7:0]  e_pc;
      logic        e_v;
      logic        e_t;
      logic [2:0]  e_d;
      logic        e_o;
      logic        e_u;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ld, input logic [7:0] lpc, input logic st,
                      input logic [15:0] ins, input logic [15:0] fl,
                      input logic [7:0] e_pc, input logic e_v, input logic e_t,
                      input logic [2:0] e_d, input logic e_o, input logic e_u);
      vec_t v;
      v = '{ld, lpc, st, ins, fl, e_pc, e_v, e_t, e_d, e_o, e_u};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic ld, input logic [7:0] lpc, input logic st,
                        input logic [15:0] ins, input logic [15:0] fl);
      bus.load_en     = ld;
      bus.load_pc     = lpc;
      bus.step        = st;
      bus.instruction = ins;
      bus.alu_flags   = fl;
   endtask

   // taken is only meaningful alongside pc_valid, so it is compared only then
   task automatic check(input string name, input logic [7:0] e_pc, input logic e_v,
                        input logic e_t, input logic [2:0] e_d, input logic e_o,
                        input logic e_u);
      logic bad;
      n_tests++;
      bad = (bus.pc !== e_pc) || (bus.pc_valid !== e_v) || (bus.stack_depth !== e_d) ||
            (bus.overflow !== e_o) || (bus.underflow !== e_u) ||
            (e_v && (bus.taken !== e_t));
      if (bad) begin
         n_fail++;
         $display("FAIL %s: got pc=%h v=%b t=%b d=%0d ov=%b un=%b, expected pc=%h v=%b t=%b d=%0d ov=%b un=%b",
                  name, bus.pc, bus.pc_valid, bus.taken, bus.stack_depth, bus.overflow,
                  bus.underflow, e_pc, e_v, e_t, e_d, e_o, e_u);
      end
   endtask

   initial begin
      drive(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("reset", 8'h10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;

      //   ld    lpc    st    ins        fl         pc     v     t     d     ov    un
      add(1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000, 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000, 8'h12, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000, 8'h13, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 8'h13, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0A56, 16'h0001, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0A56, 16'h0002, 8'hA6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0A56, 16'h0003, 8'hA7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b1, 8'h20, 1'b0, 16'h0000, 16'h0000, 8'h20, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2402, 16'h0000, 8'h40, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h21, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h1F56, 16'h0000, 8'hF5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h5A52, 16'h0000, 8'hF6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b1, 8'hFF, 1'b0, 16'h0000, 16'h0000, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h1A51, 16'h0000, 8'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b1, 8'h50, 1'b0, 16'h0000, 16'h0000, 8'h50, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2102, 16'h0000, 8'h10, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2202, 16'h0000, 8'h20, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2302, 16'h0000, 8'h30, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2402, 16'h0000, 8'h40, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h2502, 16'h0000, 8'h50, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h31, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h21, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h11, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h51, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h52, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
      add(1'b0, 8'h00, 1'b1, 16'h2402, 16'h0000, 8'h40, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
      add(1'b1, 8'h33, 1'b1, 16'h2402, 16'h0000, 8'h33, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1);
      add(1'b0, 8'h00, 1'b1, 16'h3002, 16'h0000, 8'h53, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      add(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 8'h53, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].lpc, vecs[i].st, vecs[i].ins, vecs[i].fl);
         @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v, vecs[i].e_t,
               vecs[i].e_d, vecs[i].e_o, vecs[i].e_u);
      end

      // Mid-sequence reset: two calls, then reset with a coincident call step.
      drive(1'b0, 8'h00, 1'b1, 16'h2102, 16'h0000);
      @(negedge clk);
      check("pre_rst_call1", 8'h10, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 16'h2202, 16'h0000);
      @(negedge clk);
      check("pre_rst_call2", 8'h20, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 16'h2402, 16'h0000);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset", 8'h10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      check("post_reset_idle", 8'h10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000);
      @(negedge clk);
      check("post_reset_step", 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      check("post_reset_valid_drop", 8'h11, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
